// File: rtl/conv5x5_engine.sv
// rtl/conv5x5_engine.sv - sequential 5x5 int8 multiply-accumulate engine, one kernel row per cycle
module conv5x5_engine (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [4:0][4:0][7:0] weights,
    input  logic signed [4:0][4:0][7:0] inputs,
    output logic signed [31:0]        outputs,
    output logic                      done,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t              state;
    logic [4:0][4:0][7:0] in_r;
    logic [4:0][4:0][7:0] w_r;
    logic signed [20:0]  acc;
    logic [2:0]          row;

    logic signed [15:0]  prod [5];
    logic signed [18:0]  row_sum;
    logic signed [20:0]  acc_next;

    // Five multipliers shared across the rows of the latched window.
    always_comb begin
        row_sum = '0;
        for (int c = 0; c < 5; c++) begin
            prod[c] = $signed(in_r[row][c]) * $signed(w_r[row][c]);
            row_sum = row_sum + {{3{prod[c][15]}}, prod[c]};
        end
        acc_next = acc + {{2{row_sum[18]}}, row_sum};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            outputs <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            acc     <= '0;
            row     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        in_r  <= inputs;
                        w_r   <= weights;
                        acc   <= '0;
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    row <= row + 3'd1;
                    if (row == 3'd4) begin
                        outputs <= {{11{acc_next[20]}}, acc_next};
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv5x5_engine.sv
// tb/tb_conv5x5_engine.sv - directed bench for conv5x5_engine with hand-computed results
module tb_conv5x5_engine;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic signed [4:0][4:0][7:0] weights;
    logic signed [4:0][4:0][7:0] inputs;
    logic signed [31:0]          outputs;
    logic                        done;
    logic                        busy;

    int passes = 0;
    int total  = 0;
    int n;

    conv5x5_engine dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .weights (weights),
        .inputs  (inputs),
        .outputs (outputs),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, $signed(obs), obs, $signed(exp), exp);
    endtask

    task automatic set_all(input logic [7:0] xv, input logic [7:0] wv);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                inputs[r][c]  = xv;
                weights[r][c] = wv;
            end
    endtask

    // Pulse start for one cycle, then wait (bounded) for done; leaves the bench in the done cycle.
    task automatic run_conv(input string tag, input logic [31:0] exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 12) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 6);
        chk({tag, "_value"}, outputs, exp);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_all(8'd0, 8'd0);
        tick();
        tick();
        chk("reset_outputs", outputs, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        tick();

        // All ones: busy through T+1..T+6, done only at T+6.
        set_all(8'd1, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("ones_busy_t%0d", i), {31'd0, busy}, 1);
            chk($sformatf("ones_nodone_t%0d", i), {31'd0, done}, 0);
            tick();
        end
        chk("ones_done_t6", {31'd0, done}, 1);
        chk("ones_busy_t6", {31'd0, busy}, 1);
        chk("ones_value", outputs, 25);
        tick();
        chk("ones_done_t7", {31'd0, done}, 0);
        chk("ones_busy_t7", {31'd0, busy}, 0);

        // Extremes.
        set_all(8'sd127, -8'sd128);
        run_conv("ext_neg", 32'hFFF9CC80);
        tick();
        set_all(-8'sd128, -8'sd128);
        run_conv("ext_pos", 32'h00064000);
        tick();

        // Identity kernel with inputs scrambled after acceptance.
        set_all(8'd0, 8'd0);
        weights[2][2] = 8'sd1;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                inputs[r][c] = 8'(5 * r + c);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 12) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) begin
                    inputs[r][c]  = 8'($urandom);
                    weights[r][c] = 8'($urandom);
                end
            tick();
            n++;
        end
        chk("ident_latency", n, 6);
        chk("ident_value", outputs, 12);
        tick();

        // Held start: back-to-back acceptances every 7 cycles.
        set_all(8'd1, 8'd1);
        start = 1'b1;
        tick();
        set_all(8'd2, 8'd1);
        n = 1;
        while (!done && n < 12) begin
            tick();
            n++;
        end
        chk("held_first_latency", n, 6);
        chk("held_first_value", outputs, 25);
        tick();
        for (int i = 7; i <= 12; i++) begin
            chk($sformatf("held_stable_t%0d", i), outputs, 25);
            chk($sformatf("held_nodone_t%0d", i), {31'd0, done}, 0);
            tick();
        end
        chk("held_second_done", {31'd0, done}, 1);
        chk("held_second_value", outputs, 50);
        start = 1'b0;
        tick();

        // Reset in cycle T+3 discards the computation.
        set_all(8'd3, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_outputs", outputs, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midrst_nodone_%0d", i), {31'd0, done}, 0);
            tick();
        end
        run_conv("after_rst", 75);
        tick();

        // Start only during DONE is not accepted.
        set_all(8'd1, 8'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 12) begin
            tick();
            n++;
        end
        chk("donestart_latency", n, 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("donestart_busy_%0d", i), {31'd0, busy}, 0);
            tick();
        end
        chk("donestart_nodone", {31'd0, done}, 0);

        // Reset together with start: no acceptance.
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rststart_busy0", {31'd0, busy}, 0);
        tick();
        chk("rststart_busy1", {31'd0, busy}, 0);
        chk("rststart_done", {31'd0, done}, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
